// File: rtl/cmpx_core_host.sv
// cmpx_core_host: bridges a parallel request/response handshake to the core's
// 4-word input burst and 3-word output burst, with timeout and short-burst status.
module cmpx_core_host #(
   parameter int DATA_W  = 16,
   parameter int OUT_W   = 36,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mode,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_b1,
   output logic              core_in_valid,
   output logic [DATA_W-1:0] core_in,
   output logic              core_in_mode,
   input  logic              core_out_valid,
   input  logic [OUT_W-1:0]  core_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_mode,
   output logic [OUT_W-1:0]  rsp_r0,
   output logic [OUT_W-1:0]  rsp_r1,
   output logic [OUT_W-1:0]  rsp_r2,
   output logic [1:0]        rsp_status
);
   localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;
   state_t state, state_nx;
   logic [DATA_W-1:0] a1, b0, b1;
   logic [1:0] scnt, rcnt;
   logic [WW-1:0] wcnt;

   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = req_valid ? SEND : IDLE;
         SEND: state_nx = scnt == 2'd3 ? WAIT : SEND;
         WAIT: state_nx = core_out_valid ? RECV : (wcnt == W_LAST ? RESP : WAIT);
         RECV: state_nx = (!core_out_valid || rcnt == 2'd2) ? RESP : RECV;
         RESP: state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   // a0 goes straight out on the accepting edge, so only a1/b0/b1 are held
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         a1            <= '0;
         b0            <= '0;
         b1            <= '0;
         scnt          <= '0;
         rcnt          <= '0;
         wcnt          <= '0;
         core_in_valid <= 1'b0;
         core_in       <= '0;
         core_in_mode  <= 1'b0;
         rsp_mode      <= 1'b0;
         rsp_r0        <= '0;
         rsp_r1        <= '0;
         rsp_r2        <= '0;
         rsp_status    <= 2'b00;
      end else begin
         state         <= state_nx;
         core_in_valid <= 1'b0;
         core_in       <= '0;
         core_in_mode  <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               a1            <= req_a1;
               b0            <= req_b0;
               b1            <= req_b1;
               rsp_mode      <= req_mode;
               rsp_r0        <= '0;
               rsp_r1        <= '0;
               rsp_r2        <= '0;
               rsp_status    <= 2'b00;
               scnt          <= '0;
               core_in_valid <= 1'b1;
               core_in       <= req_a0;
               core_in_mode  <= req_mode;
            end
            SEND: begin
               scnt <= scnt + 2'd1;
               wcnt <= '0;
               if (scnt != 2'd3) begin
                  core_in_valid <= 1'b1;
                  core_in_mode  <= rsp_mode;
                  core_in       <= scnt == 2'd0 ? a1 : (scnt == 2'd1 ? b0 : b1);
               end
            end
            WAIT: if (core_out_valid) begin
               rsp_r0 <= core_out;
               rcnt   <= 2'd1;
            end else begin
               wcnt <= wcnt + 1'b1;
               if (wcnt == W_LAST) rsp_status <= 2'b10;
            end
            RECV: if (core_out_valid) begin
               if (rcnt == 2'd1) rsp_r1 <= core_out;
               else rsp_r2 <= core_out;
               rcnt <= rcnt + 2'd1;
            end else rsp_status <= 2'b01;
            default: ;
         endcase
      end
   end
endmodule
